// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between producers, the write arbiter and the FIFO write port.
// master = producer/FIFO side, slave = arbiter side.
interface fifo_write_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [N-1:0]    req;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            ffull;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;

    modport master (
        output req, req_last, req_data, ffull,
        input  gnt, fifo_wr, fifo_din
    );

    modport slave (
        input  req, req_last, req_data, ffull,
        output gnt, fifo_wr, fifo_din
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between N producers.
// One owner is locked per burst of up to BURST beats; stalls on ffull.
module fifo_write_arbiter #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int OW   = (N > 1) ? $clog2(N) : 1,
    localparam int CW   = $clog2(BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_write_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [OW-1:0]        owner,
    output logic [CW-1:0]        beat_cnt
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] rr_q;
    logic [CW-1:0] cnt_q;

    logic [DW-1:0] dat [N];
    logic [OW-1:0] pick;
    logic [OW-1:0] nxt_owner;
    logic          own_req;
    logic          accept;
    logic          burst_end;

    for (genvar g = 0; g < N; g++) begin : g_split
        assign dat[g] = bus.req_data[g*DW +: DW];
    end

    // Round-robin search starting at rr_q, wrapping modulo N
    always_comb begin
        int   idx;
        logic found;
        pick  = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req[OW'(idx)]) begin
                pick  = OW'(idx);
                found = 1'b1;
            end
        end
    end

    assign own_req   = bus.req[owner_q];
    assign accept    = (state_q == BUSY) && own_req && !bus.ffull;
    assign burst_end = bus.req_last[owner_q] || (cnt_q == CW'(BURST - 1));
    assign nxt_owner = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

    // Grant and FIFO write follow ffull and the owner's req combinationally
    always_comb begin
        bus.gnt = '0;
        if (state_q == BUSY && !bus.ffull) bus.gnt[owner_q] = 1'b1;
        bus.fifo_wr  = accept;
        bus.fifo_din = accept ? dat[owner_q] : '0;
    end

    // Arbitration FSM: lock an owner, count beats, rotate on exit
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        owner_q <= pick;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_req) begin
                        state_q <= IDLE;
                        rr_q    <= nxt_owner;
                    end else if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (burst_end) begin
                            state_q <= IDLE;
                            rr_q    <= nxt_owner;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == BUSY);
    assign owner    = owner_q;
    assign beat_cnt = cnt_q;
endmodule
